// File: rtl/dmcache_pkg.sv
// dmcache_pkg: shared FSM state encodings, memory direction codes and clog2 helper
package dmcache_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        FILL   = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;
    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/dmcache_if.sv
// dmcache_if: cpu data port plus main-memory bus; slave = cache side, master = cpu/memory side
interface dmcache_if;
    logic        re;
    logic        we;
    logic [29:0] adr;
    logic [31:0] writedata;
    logic [3:0]  byteen;
    logic [31:0] readdata;
    logic        ack;
    logic        inval;
    logic [29:0] memadr;
    logic [31:0] memwdata;
    logic [3:0]  membyteen;
    logic        memrwb;
    logic        memen;
    logic [31:0] memrdata;
    logic        memdone;
    modport slave (
        input  re, we, adr, writedata, byteen, inval, memrdata, memdone,
        output readdata, ack, memadr, memwdata, membyteen, memrwb, memen
    );
    modport master (
        output re, we, adr, writedata, byteen, inval, memrdata, memdone,
        input  readdata, ack, memadr, memwdata, membyteen, memrwb, memen
    );
endinterface

// File: rtl/dmcache_array.sv
// dmcache_array: tag ram, byte-enabled data ram and valid vector; async read, sync write on ph1
// ports: idx selects the line for tag/valid lookup and set/unset; raddr/waddr = {index, word}
module dmcache_array #(
    parameter int IDXW = 6,
    parameter int AW   = 8
) (
    input  logic          ph1,
    input  logic          reset,
    input  logic          clr,
    input  logic [IDXW-1:0] idx,
    input  logic          set,
    input  logic          unset,
    input  logic [29-AW:0] stag,
    output logic [29-AW:0] ltag,
    output logic          lvalid,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wbe
);
    logic [31:0]     data [2**AW];
    logic [29-AW:0]  tags [2**IDXW];
    logic [2**IDXW-1:0] valid;

    always_ff @(posedge ph1) begin
        if (reset || clr) valid <= '0;
        else if (set) valid[idx] <= 1'b1;
        else if (unset) valid[idx] <= 1'b0;
    end

    always_ff @(posedge ph1) begin
        if (set) tags[idx] <= stag;
        for (int b = 0; b < 4; b++)
            if (wen && wbe[b]) data[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end

    assign rdata  = data[raddr];
    assign ltag   = tags[idx];
    assign lvalid = valid[idx];
endmodule

// File: rtl/dmcache.sv
// dmcache: direct-mapped write-through no-write-allocate data cache
// ports: ph1 clock, reset sync active-high, bus.slave = cpu data port + main-memory bus
module dmcache
    import dmcache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input logic ph1,
    input logic reset,
    dmcache_if.slave bus
);
    localparam int IDXW = clog2(LINES);
    localparam int OFFW = clog2(WORDS);
    localparam int AW   = IDXW + OFFW;
    localparam int TAGW = 30 - AW;
    localparam int CW   = (OFFW > 0) ? OFFW : 1;

    state_t state, state_n;
    logic [29:0] radr, radr_n, madr_q, madr_n, base;
    logic [31:0] rd_q, rd_n, mwd_q, mwd_n, rdata, wdata;
    logic [3:0]  mbe_q, mbe_n;
    logic [CW-1:0] cnt, cnt_n;
    logic ack_q, ack_n, men_q, men_n, mrwb_q, mrwb_n, inv_q, inv_n;
    logic clr, set, unset, wen, hit, lvalid, req, last;
    logic [TAGW-1:0] rtag, ltag;

    assign rtag = radr[29:AW];
    assign hit  = lvalid && (ltag == rtag);
    assign base = radr & ~30'(WORDS - 1);
    assign last = cnt == CW'(WORDS - 1);
    assign req  = (bus.re || bus.we) && !ack_q;
    assign wdata = (state == FILL) ? bus.memrdata : mwd_q;

    dmcache_array #(.IDXW(IDXW), .AW(AW)) arr (
        .ph1(ph1), .reset(reset), .clr(clr),
        .idx(radr[AW-1:OFFW]), .set(set), .unset(unset),
        .stag(rtag), .ltag(ltag), .lvalid(lvalid),
        .raddr(radr[AW-1:0]), .rdata(rdata),
        .wen(wen), .waddr(madr_q[AW-1:0]), .wdata(wdata), .wbe(mbe_q)
    );

    always_ff @(posedge ph1) begin
        if (reset) begin
            state  <= IDLE;
            radr   <= '0;
            madr_q <= '0;
            rd_q   <= '0;
            mwd_q  <= '0;
            mbe_q  <= '0;
            cnt    <= '0;
            ack_q  <= 1'b0;
            men_q  <= 1'b0;
            mrwb_q <= MEM_RD;
            inv_q  <= 1'b0;
        end else begin
            state  <= state_n;
            radr   <= radr_n;
            madr_q <= madr_n;
            rd_q   <= rd_n;
            mwd_q  <= mwd_n;
            mbe_q  <= mbe_n;
            cnt    <= cnt_n;
            ack_q  <= ack_n;
            men_q  <= men_n;
            mrwb_q <= mrwb_n;
            inv_q  <= inv_n;
        end
    end

    // mem outputs are registered; madr_q doubles as the fill/write array address
    always_comb begin
        state_n = state;
        radr_n  = radr;
        madr_n  = madr_q;
        rd_n    = rd_q;
        mwd_n   = mwd_q;
        mbe_n   = mbe_q;
        cnt_n   = cnt;
        ack_n   = 1'b0;
        men_n   = men_q;
        mrwb_n  = mrwb_q;
        inv_n   = inv_q || bus.inval;
        clr     = 1'b0;
        set     = 1'b0;
        unset   = 1'b0;
        wen     = 1'b0;
        case (state)
            IDLE: begin
                if (inv_q || (bus.inval && !req)) begin
                    clr   = 1'b1;
                    inv_n = 1'b0;
                end else if (req) begin
                    radr_n = bus.adr;
                    mwd_n  = bus.writedata;
                    mbe_n  = bus.byteen;
                    if (bus.we) begin
                        state_n = WRITE;
                        men_n   = 1'b1;
                        mrwb_n  = MEM_WR;
                        madr_n  = bus.adr;
                    end else state_n = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    rd_n    = rdata;
                    ack_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = FILL;
                    unset   = 1'b1;
                    cnt_n   = '0;
                    men_n   = 1'b1;
                    mrwb_n  = MEM_RD;
                    mbe_n   = 4'hF;
                    madr_n  = base;
                end
            end
            FILL: begin
                if (men_q && bus.memdone) begin
                    wen   = 1'b1;
                    cnt_n = cnt + 1'b1;
                    men_n = 1'b0;
                    if (last) begin
                        set     = 1'b1;
                        state_n = RESP;
                    end
                end else if (!men_q) begin
                    men_n  = 1'b1;
                    madr_n = base | 30'(cnt);
                end
            end
            RESP: begin
                rd_n    = rdata;
                ack_n   = 1'b1;
                state_n = IDLE;
            end
            WRITE: begin
                if (men_q && bus.memdone) begin
                    wen     = hit;
                    men_n   = 1'b0;
                    mrwb_n  = MEM_RD;
                    ack_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.readdata  = rd_q;
    assign bus.ack       = ack_q;
    assign bus.memadr    = madr_q;
    assign bus.memwdata  = mwd_q;
    assign bus.membyteen = mbe_q;
    assign bus.memrwb    = mrwb_q;
    assign bus.memen     = men_q;
endmodule
